// File: rtl/axi_lite_uart_tx_master_if.sv
// AXI-Lite bundle with 32-bit address and data, seen from the master or the slave side.
interface AXI_LITE;
   logic        aw_valid;
   logic        aw_ready;
   logic [31:0] aw_addr;
   logic [2:0]  aw_prot;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        b_valid;
   logic        b_ready;
   logic [1:0]  b_resp;
   logic        ar_valid;
   logic        ar_ready;
   logic [31:0] ar_addr;
   logic [2:0]  ar_prot;
   logic        r_valid;
   logic        r_ready;
   logic [31:0] r_data;
   logic [1:0]  r_resp;

   modport Master (
      output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
             ar_valid, ar_addr, ar_prot, r_ready,
      input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
   );

   modport Slave (
      input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
             ar_valid, ar_addr, ar_prot, r_ready,
      output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
   );
endinterface

// File: rtl/axi_lite_uart_tx_master.sv
// Byte stream -> FIFO -> one AXI-Lite write per byte to the UART transmit-data register.
// Optional UART_TX_POLL_EN: poll the status register until READY_BIT is set before each write.
module axi_lite_uart_tx_master #(
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
   parameter logic [4:0]  TX_OFFSET     = 5'h04,
   parameter logic [4:0]  STATUS_OFFSET = 5'h08,
   parameter int unsigned READY_BIT     = 0,
   parameter int unsigned FIFO_DEPTH    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   AXI_LITE.Master     axi,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_data,
   output logic        busy,
   output logic [15:0] tx_count,
   output logic [7:0]  err_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [31:0] TX_ADDR = BASE_ADDR + 32'(TX_OFFSET);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
`ifdef UART_TX_POLL_EN
      RESP,
      POLL_AR,
      POLL_R
`else
      RESP
`endif
   } state_t;

   state_t          state;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;
   logic [7:0]      hold;
   logic            aw_valid_q;
   logic            w_valid_q;
   logic            b_ready_q;
   logic            push;
   logic            pop;
   logic            idle_nxt;
   logic            unused_rd;

   assign push      = s_valid & s_ready;
   assign count_nxt = count + CW'(push) - CW'(pop);
   assign idle_nxt  = ((state == IDLE) & (count == '0)) | ((state == RESP) & axi.b_valid);

`ifdef UART_TX_POLL_EN
   localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'(STATUS_OFFSET);
   logic ar_valid_q;
   logic r_ready_q;

   // The byte leaves the FIFO only once the transmitter reports it can take it.
   assign pop = (state == POLL_R) & axi.r_valid & axi.r_data[READY_BIT] & (axi.r_resp == 2'b00);

   assign axi.ar_valid = ar_valid_q;
   assign axi.ar_addr  = STATUS_ADDR;
   assign axi.ar_prot  = 3'b000;
   assign axi.r_ready  = r_ready_q;
`else
   assign pop = (state == IDLE) & (count != '0);

   assign axi.ar_valid = 1'b0;
   assign axi.ar_addr  = 32'h0;
   assign axi.ar_prot  = 3'b000;
   assign axi.r_ready  = 1'b0;
`endif

   assign unused_rd = ^{axi.ar_ready, axi.r_valid, axi.r_data, axi.r_resp,
                        STATUS_OFFSET, 32'(READY_BIT)};

   assign axi.aw_valid = aw_valid_q;
   assign axi.aw_addr  = TX_ADDR;
   assign axi.aw_prot  = 3'b000;
   assign axi.w_valid  = w_valid_q;
   assign axi.w_data   = {24'h0, hold};
   assign axi.w_strb   = 4'b0001;
   assign axi.b_ready  = b_ready_q;

   // FIFO storage, no reset needed: occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         hold       <= 8'h00;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         s_ready    <= 1'b0;
         busy       <= 1'b0;
         tx_count   <= 16'h0000;
         err_count  <= 8'h00;
`ifdef UART_TX_POLL_EN
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
`endif
      end else begin
         count   <= count_nxt;
         s_ready <= (count_nxt != CW'(FIFO_DEPTH));
         busy    <= ~idle_nxt | (count_nxt != '0);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            hold   <= mem[rd_ptr];
         end

         case (state)
            IDLE: begin
               if (count != '0) begin
`ifdef UART_TX_POLL_EN
                  ar_valid_q <= 1'b1;
                  state      <= POLL_AR;
`else
                  aw_valid_q <= 1'b1;
                  w_valid_q  <= 1'b1;
                  state      <= WRITE;
`endif
               end
            end

            // Address and data channels complete independently.
            WRITE: begin
               if (axi.aw_ready) aw_valid_q <= 1'b0;
               if (axi.w_ready)  w_valid_q  <= 1'b0;
               if ((~aw_valid_q | axi.aw_ready) & (~w_valid_q | axi.w_ready)) begin
                  b_ready_q <= 1'b1;
                  state     <= RESP;
               end
            end

            RESP: begin
               if (axi.b_valid) begin
                  b_ready_q <= 1'b0;
                  tx_count  <= tx_count + 16'd1;
                  if ((axi.b_resp != 2'b00) && (err_count != 8'hFF))
                     err_count <= err_count + 8'd1;
                  state <= IDLE;
               end
            end

`ifdef UART_TX_POLL_EN
            POLL_AR: begin
               if (axi.ar_ready) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state      <= POLL_R;
               end
            end

            POLL_R: begin
               if (axi.r_valid) begin
                  r_ready_q <= 1'b0;
                  if (pop) begin
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                     state      <= WRITE;
                  end else begin
                     ar_valid_q <= 1'b1;
                     state      <= POLL_AR;
                     if ((axi.r_resp != 2'b00) && (err_count != 8'hFF))
                        err_count <= err_count + 8'd1;
                  end
               end
            end
`endif

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_uart_tx_master.sv
// Directed bench for axi_lite_uart_tx_master with a small behavioural AXI-Lite slave.
module tb_axi_lite_uart_tx_master;

   logic        clk;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        busy;
   logic [15:0] tx_count;
   logic [7:0]  err_count;

   logic        aw_rdy;
   logic        w_rdy;
   int          err_at;

   int          n_checks;
   int          n_errs;

   // slave-side bookkeeping
   logic [31:0] aw_log [$];
   logic [31:0] wd_log [$];
   logic [31:0] ws_log [$];
   logic [31:0] ar_log [$];
   logic [31:0] st_q [$];
   int          st_rd;
   int          aw_cnt;
   int          b_cnt;
   logic        aw_got;
   logic        w_got;
   logic        ar_seen;

   AXI_LITE axi ();

   axi_lite_uart_tx_master dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .axi       (axi),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .busy      (busy),
      .tx_count  (tx_count),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign axi.aw_ready = aw_rdy;
   assign axi.w_ready  = w_rdy;
   assign axi.ar_ready = 1'b1;

   initial begin
      aw_cnt  = 0;
      b_cnt   = 0;
      st_rd   = 0;
      ar_seen = 1'b0;
   end

   // Slave: logs both write channels, answers B once both are in, answers reads from st_q.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         axi.b_valid <= 1'b0;
         axi.b_resp  <= 2'b00;
         axi.r_valid <= 1'b0;
         axi.r_data  <= 32'h0;
         axi.r_resp  <= 2'b00;
         aw_got      <= 1'b0;
         w_got       <= 1'b0;
      end else begin
         if (axi.aw_valid && axi.aw_ready) begin
            aw_got <= 1'b1;
            aw_log.push_back(axi.aw_addr);
            aw_cnt <= aw_cnt + 1;
         end
         if (axi.w_valid && axi.w_ready) begin
            w_got <= 1'b1;
            wd_log.push_back(axi.w_data);
            ws_log.push_back(32'(axi.w_strb));
         end
         if (!axi.b_valid && aw_got && w_got) begin
            axi.b_valid <= 1'b1;
            axi.b_resp  <= (b_cnt == err_at) ? 2'b10 : 2'b00;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
         end
         if (axi.b_valid && axi.b_ready) begin
            axi.b_valid <= 1'b0;
            b_cnt       <= b_cnt + 1;
         end
         if (axi.ar_valid && axi.ar_ready) begin
            axi.r_valid <= 1'b1;
            axi.r_resp  <= 2'b00;
            ar_log.push_back(axi.ar_addr);
            if (st_rd < st_q.size()) begin
               axi.r_data <= st_q[st_rd];
               st_rd      <= st_rd + 1;
            end else begin
               axi.r_data <= 32'h1;
            end
         end
         if (axi.r_valid && axi.r_ready) axi.r_valid <= 1'b0;
         if (axi.ar_valid) ar_seen <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errs++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b);
      bit ok;
      ok      = 1'b0;
      s_valid = 1'b1;
      s_data  = b;
      for (int i = 0; i < 50; i++) begin
         if (s_ready) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      s_valid = 1'b0;
      chk("push_accepted", 32'(ok), 32'h1);
   endtask

   task automatic wait_b(input int target);
      for (int i = 0; i < 400; i++) begin
         if (b_cnt >= target) break;
         tick();
      end
      chk("b_wait_timeout", 32'(b_cnt >= target), 32'h1);
   endtask

   task automatic wait_aw_valid();
      for (int i = 0; i < 50; i++) begin
         if (axi.aw_valid) break;
         tick();
      end
      chk("aw_valid_wait", 32'(axi.aw_valid), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int base;
      bit go;

      n_checks = 0;
      n_errs   = 0;
      rst_n    = 1'b0;
      s_valid  = 1'b0;
      s_data   = 8'h00;
      aw_rdy   = 1'b1;
      w_rdy    = 1'b1;
      err_at   = -1;

      repeat (3) tick();
      chk("rst_aw_valid", 32'(axi.aw_valid), 32'h0);
      chk("rst_w_valid",  32'(axi.w_valid),  32'h0);
      chk("rst_b_ready",  32'(axi.b_ready),  32'h0);
      chk("rst_s_ready",  32'(s_ready),      32'h0);
      chk("rst_busy",     32'(busy),         32'h0);
      chk("rst_tx_count", 32'(tx_count),     32'h0);
      chk("rst_err_count",32'(err_count),    32'h0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_s_ready", 32'(s_ready), 32'h1);

      // "Hi" against an always-ready slave
      push(8'h48);
`ifndef UART_TX_POLL_EN
      chk("lat_aw_valid_early", 32'(axi.aw_valid), 32'h0);
      tick();
      chk("lat_aw_valid", 32'(axi.aw_valid), 32'h1);
      chk("lat_w_valid",  32'(axi.w_valid),  32'h1);
      chk("lat_w_data",   axi.w_data,        32'h48);
`endif
      push(8'h69);
      wait_b(2);
      chk("hi_busy_low",  32'(busy),     32'h0);
      chk("hi_tx_count",  32'(tx_count), 32'd2);
      chk("hi_addr0",     aw_log[0],     32'h04);
      chk("hi_addr1",     aw_log[1],     32'h04);
      chk("hi_data0",     wd_log[0],     32'h48);
      chk("hi_data1",     wd_log[1],     32'h69);
      chk("hi_strb0",     ws_log[0],     32'h1);
      chk("hi_strb1",     ws_log[1],     32'h1);

      // Address channel stalled, data channel ready
      aw_rdy = 1'b0;
      push(8'h41);
      wait_aw_valid();
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("stall_w_valid",  32'(axi.w_valid),  32'h0);
         chk("stall_aw_valid", 32'(axi.aw_valid), 32'h1);
         chk("stall_aw_addr",  axi.aw_addr,       32'h04);
         chk("stall_b_ready",  32'(axi.b_ready),  32'h0);
         tick();
      end
      aw_rdy = 1'b1;
      tick();
      chk("stall_aw_dropped", 32'(axi.aw_valid), 32'h0);
      chk("stall_b_ready_up", 32'(axi.b_ready),  32'h1);
      wait_b(3);
      repeat (3) tick();
      chk("stall_aw_cnt",   32'(aw_cnt),   32'd3);
      chk("stall_tx_count", 32'(tx_count), 32'd3);
      chk("stall_data",     wd_log[2],     32'h41);

      // Capacity: FIFO_DEPTH in the FIFO plus one in the holding register
      aw_rdy  = 1'b0;
      acc     = 0;
      for (int c = 0; c < 30; c++) begin
         s_valid = (acc < 12);
         s_data  = 8'h30 + 8'(acc);
         go      = s_valid && s_ready;
         tick();
         if (go) acc++;
      end
      s_valid = 1'b0;
      chk("cap_accepted", 32'(acc),     32'd9);
      chk("cap_s_ready",  32'(s_ready), 32'h0);
      aw_rdy = 1'b1;
      wait_b(12);
      repeat (4) tick();
      for (int k = 0; k < 9; k++)
         chk("cap_data", wd_log[3 + k], 32'h30 + 32'(k));
      chk("cap_aw_cnt",   32'(aw_cnt),   32'd12);
      chk("cap_tx_count", 32'(tx_count), 32'd12);
      chk("cap_busy",     32'(busy),     32'h0);

      // Error response on the first of three writes
      err_at = 12;
      push(8'h61);
      push(8'h62);
      push(8'h63);
      wait_b(15);
      tick();
      chk("err_err_count", 32'(err_count), 32'd1);
      chk("err_tx_count",  32'(tx_count),  32'd15);
      chk("err_data0",     wd_log[12],     32'h61);
      chk("err_data1",     wd_log[13],     32'h62);
      chk("err_data2",     wd_log[14],     32'h63);
      err_at = -1;

`ifdef UART_TX_POLL_EN
      // Status reads 0, 0, 1 before the write goes out
      base = ar_log.size();
      st_q.push_back(32'h0);
      st_q.push_back(32'h0);
      st_q.push_back(32'h1);
      push(8'h5A);
      wait_b(16);
      tick();
      chk("poll_ar_count", 32'(ar_log.size() - base), 32'd3);
      chk("poll_ar_addr0", ar_log[base],              32'h08);
      chk("poll_ar_addr2", ar_log[base + 2],          32'h08);
      chk("poll_data",     wd_log[15],                32'h5A);
      chk("poll_aw_cnt",   32'(aw_cnt),               32'd16);
`else
      chk("no_ar_valid", 32'(ar_seen), 32'h0);
`endif

      // Asynchronous reset in the middle of a write
      aw_rdy = 1'b0;
      w_rdy  = 1'b0;
      push(8'h77);
      wait_aw_valid();
      base = aw_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_aw_valid", 32'(axi.aw_valid), 32'h0);
      chk("arst_w_valid",  32'(axi.w_valid),  32'h0);
      chk("arst_b_ready",  32'(axi.b_ready),  32'h0);
      chk("arst_s_ready",  32'(s_ready),      32'h0);
      chk("arst_busy",     32'(busy),         32'h0);
      repeat (2) tick();
      rst_n  = 1'b1;
      aw_rdy = 1'b1;
      w_rdy  = 1'b1;
      tick();
      chk("arst_tx_count",  32'(tx_count),  32'h0);
      chk("arst_err_count", 32'(err_count), 32'h0);
      for (int i = 0; i < 8; i++) begin
         chk("arst_no_write", 32'(axi.aw_valid), 32'h0);
         tick();
      end
      chk("arst_aw_cnt",  32'(aw_cnt),  32'(base));
      chk("arst_busy_end",32'(busy),    32'h0);
      chk("arst_s_ready_end", 32'(s_ready), 32'h1);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_uart_tx_master.md
Name: axi_lite_uart_tx_master

Overview:
- AXI-Lite initiator that drains a byte stream into a UART-style transmit-data register.
- Counterpart to the simulation UART slave.
- Accepts bytes on a valid/ready input, buffers them in a small FIFO, and issues one single-beat AXI-Lite write per byte to BASE_ADDR+TX_OFFSET.
- Used by sim benches and on-chip debug logic to print characters over the AXI-Lite peripheral bus.

Parameters:
- BASE_ADDR, 32'h0000_0000, peripheral base address.
- TX_OFFSET, 5'h04, transmit-data register offset.
- STATUS_OFFSET, 5'h08, status register offset (used only with the optional feature).
- READY_BIT, 0, bit of the status word that means "transmitter can accept a byte".
- FIFO_DEPTH, 8, input FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- axi  AXI_LITE.Master  -  AXI-Lite master port; 32-bit addr, 32-bit data.
- s_valid  input  1  input byte valid.
- s_ready  output  1  FIFO can accept a byte.
- s_data  input  8  input byte.
- busy  output  1  FIFO non-empty or transaction in flight.
- tx_count  output  16  bytes whose write response has been received; wraps at 16'hFFFF->0.
- err_count  output  8  responses with bresp != OKAY; saturates at 8'hFF.

Behaviour:
- Reset (async, rst_n low): FIFO empty, state IDLE, all AXI valid/ready outputs 0, s_ready 0 while in reset, tx_count 0, err_count 0, busy 0. All outputs deassert immediately, even mid-transaction. No write is resumed after reset release.
- FIFO push on s_valid & s_ready. s_ready = ~full, registered-state based, with no combinational path from s_valid.
- Constant write fields:
  - aw_addr = BASE_ADDR + TX_OFFSET.
  - aw_prot = 3'b000.
  - w_data = {24'h0, byte}.
  - w_strb = 4'b0001.
- FSM states: IDLE, WRITE, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head into a holding register, set aw_valid=1 and w_valid=1, and go to WRITE.
  - Registered latency: for a byte pushed at edge N into an empty FIFO, aw_valid and w_valid are high after edge N+1.
- WRITE:
  - aw_valid drops on the cycle after the aw handshake; w_valid drops on the cycle after the w handshake. The two channels are independent, so either may complete first or both in the same cycle.
  - When both have completed, go to RESP with b_ready=1.
  - AXI rule: once raised, valid holds and its payload stays stable until the handshake.
- RESP:
  - b_ready=1. On b_valid: tx_count += 1; if bresp != 2'b00, err_count += 1 (saturating). Then clear b_ready and go to IDLE.
  - An error does not stop the stream; the next byte is still sent.
- Exactly one outstanding write at a time.
- Capacity: FIFO_DEPTH bytes plus 1 in the holding register.
- Simultaneous push and pop in IDLE is allowed; FIFO occupancy is unchanged.
- Read channels without the optional feature: ar_valid=0, r_ready=0 constantly; ar_addr=0.
- busy = (state != IDLE) | ~empty.

Optional Feature:
- Macro: UART_TX_POLL_EN.
- Defined: IDLE with FIFO non-empty goes to POLL_AR instead of WRITE.
- POLL_AR: ar_valid=1, ar_addr = BASE_ADDR+STATUS_OFFSET, ar_prot=0. On handshake go to POLL_R.
- POLL_R: r_ready=1. On r_valid:
  - r_data[READY_BIT]=1 and rresp OKAY: pop the byte and go to WRITE.
  - Otherwise: go back to POLL_AR next cycle; a non-OKAY rresp also increments err_count.
- Not defined: the AR/R channels are tied off as described above and the POLL states do not exist.

Test Plan:
- Push "Hi" (0x48, 0x69) against an always-ready slave -> two writes to 0x04 with w_data 0x48 then 0x69, w_strb 4'b0001; tx_count=2; busy low 1 cycle after the second b handshake.
- Slave holds aw_ready=0 for 5 cycles while w_ready=1 -> w_valid drops after its handshake while aw_valid stays high with stable addr; b_ready rises only after aw completes; no second aw issued early.
- aw_ready held 0, push 12 bytes back-to-back with FIFO_DEPTH=8 -> exactly 9 accepted, s_ready low from the 10th; after release all 9 written in order, with no loss or duplication.
- Slave returns bresp=2'b10 on the 1st of 3 writes -> err_count=1, tx_count=3, and bytes 2 and 3 are still written.
- Assert rst_n low while in WRITE with aw_valid high -> aw_valid, w_valid, b_ready and s_ready go low without waiting for a clock edge; after release, FIFO empty, counters 0, no stray write.
- With UART_TX_POLL_EN: status reads return 0, 0, 1 -> three AR transactions to 0x08, then one write of the byte; without the macro, ar_valid never rises.
